combat_resolver: RTL and testbench



---
 rtl/combat_resolver_if.sv | 49 ++++
 rtl/combat_resolver.sv | 234 +++++++++++++++++++++++
 tb/tb_combat_resolver.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/combat_resolver_if.sv
// ---------------------------------------------------------------------------
// combat_resolver_if
// Bundles the per-frame signals exchanged between the fighter movement
// blocks, the HUD/sprite logic and the combat resolver.
//
// Signals (direction as seen by the resolver, i.e. the slave modport):
//   startscreen             in   round-start / idle, reloads health
//   p1_punch/kick/block     in   fighter 1 (right side) action flags
//   p2_punch/kick/block     in   fighter 2 (left side) action flags
//   p1_x, p1_y, p2_x, p2_y  in   fighter centre positions, unsigned 10 bit
//   p1_health, p2_health    out  current health, 8 bit
//   deathR, deathL          out  fighter 1 / fighter 2 health is zero
//   p1_hit, p2_hit          out  one-frame pulse when that fighter is damaged
//   p1_phase, p2_phase      out  attack phase 0 IDLE 1 WINDUP 2 ACTIVE 3 RECOVER
// ---------------------------------------------------------------------------
interface combat_resolver_if;
  logic       startscreen;
  logic       p1_punch, p1_kick, p1_block;
  logic       p2_punch, p2_kick, p2_block;
  logic [9:0] p1_x, p1_y, p2_x, p2_y;
  logic [7:0] p1_health, p2_health;
  logic       deathR, deathL;
  logic       p1_hit, p2_hit;
  logic [1:0] p1_phase, p2_phase;

  // The side that produces fighter actions and consumes the results.
  modport master (
    output startscreen,
    output p1_punch, p1_kick, p1_block,
    output p2_punch, p2_kick, p2_block,
    output p1_x, p1_y, p2_x, p2_y,
    input  p1_health, p2_health,
    input  deathR, deathL,
    input  p1_hit, p2_hit,
    input  p1_phase, p2_phase
  );

  // The resolver itself.
  modport slave (
    input  startscreen,
    input  p1_punch, p1_kick, p1_block,
    input  p2_punch, p2_kick, p2_block,
    input  p1_x, p1_y, p2_x, p2_y,
    output p1_health, p2_health,
    output deathR, deathL,
    output p1_hit, p2_hit,
    output p1_phase, p2_phase
  );
endinterface

// File: rtl/combat_resolver.sv
// ---------------------------------------------------------------------------
// combat_resolver
// Per-frame combat stage. Each fighter owns an attack sequencer
// (IDLE -> WINDUP -> ACTIVE -> RECOVER -> IDLE). During ACTIVE frames the
// attack is tested for reach and height against the opponent; the first
// connecting frame applies damage (reduced when the defender blocks) to a
// saturating health counter. Zero health raises deathR / deathL, which
// freezes both sequencers until the next round start.
//
// Ports:
//   frame_clk   in   frame clock, all state changes on its rising edge
//   Reset_n     in   asynchronous active-low reset
//   bus_io      slave modport of combat_resolver_if (actions, positions,
//                    health, deaths, hit pulses, phase codes)
// ---------------------------------------------------------------------------
module combat_resolver #(
  parameter int HP_MAX      = 100,
  parameter int PUNCH_DMG   = 5,
  parameter int KICK_DMG    = 8,
  parameter int PUNCH_REACH = 110,
  parameter int KICK_REACH  = 130,
  parameter int Y_TOL       = 60,
  parameter int WINDUP      = 2,
  parameter int ACTIVE      = 3,
  parameter int RECOVER     = 6
) (
  input logic              frame_clk,
  input logic              Reset_n,
  combat_resolver_if.slave bus_io
);

  typedef enum logic [1:0] {
    PH_IDLE    = 2'd0,
    PH_WINDUP  = 2'd1,
    PH_ACTIVE  = 2'd2,
    PH_RECOVER = 2'd3
  } phase_e;

  localparam logic [7:0]  HP_INIT      = 8'(HP_MAX);
  localparam logic [7:0]  PUNCH_FULL   = 8'(PUNCH_DMG);
  localparam logic [7:0]  KICK_FULL    = 8'(KICK_DMG);
  localparam logic [10:0] PUNCH_RCH    = 11'(PUNCH_REACH);
  localparam logic [10:0] KICK_RCH     = 11'(KICK_REACH);
  localparam logic [10:0] Y_LIM        = 11'(Y_TOL);
  localparam logic [3:0]  WINDUP_LAST  = 4'(WINDUP - 1);
  localparam logic [3:0]  ACTIVE_LAST  = 4'(ACTIVE - 1);
  localparam logic [3:0]  RECOVER_LAST = 4'(RECOVER - 1);

  // Index 0 is fighter 1, index 1 is fighter 2.
  logic [1:0]  punchIn, kickIn, blockIn;
  logic [1:0]  connects;
  logic [1:0]  attackKick;
  logic [3:0]  phaseBits;
  logic [10:0] diffX, diffY, dx, dy;
  logic        inRangeY;
  logic        anyDeath;

  logic [7:0]  p1Health_q, p2Health_q;
  logic [7:0]  p1Health_d, p2Health_d;
  logic [7:0]  dmgP1Raw, dmgP2Raw, dmgP1, dmgP2;
  logic        p1Hit_q, p2Hit_q;
  logic        deathR_q, deathL_q;

  assign punchIn = {bus_io.p2_punch, bus_io.p1_punch};
  assign kickIn  = {bus_io.p2_kick,  bus_io.p1_kick};
  assign blockIn = {bus_io.p2_block, bus_io.p1_block};

  // Distances are formed in 11 bits so the subtraction of two 10-bit
  // positions cannot wrap; the sign bit then selects the magnitude.
  assign diffX    = {1'b0, bus_io.p1_x} - {1'b0, bus_io.p2_x};
  assign diffY    = {1'b0, bus_io.p1_y} - {1'b0, bus_io.p2_y};
  assign dx       = diffX[10] ? (~diffX + 11'd1) : diffX;
  assign dy       = diffY[10] ? (~diffY + 11'd1) : diffY;
  assign inRangeY = (dy <= Y_LIM);

  assign anyDeath = deathR_q | deathL_q;

  // One attack sequencer per fighter. Each holds its own latched attack
  // type, the landed flag that limits an attack to a single hit, and the
  // previous-frame button values used for rising-edge detection.
  for (genvar g = 0; g < 2; g++) begin : g_fighter
    phase_e      state_q;
    logic [3:0]  cnt_q;
    logic        kick_q, landed_q;
    logic        prevPunch_q, prevKick_q;
    logic        punchEdge, kickEdge;
    logic [10:0] reach;

    assign punchEdge     = punchIn[g] & ~prevPunch_q;
    assign kickEdge      = kickIn[g] & ~prevKick_q;
    assign reach         = kick_q ? KICK_RCH : PUNCH_RCH;
    assign connects[g]   = (state_q == PH_ACTIVE) && !landed_q &&
                           inRangeY && (dx <= reach);
    assign attackKick[g] = kick_q;
    assign phaseBits[2*g +: 2] = state_q;

    // The phase register is itself the phase output, so the HUD sees a
    // registered code. Each non-idle phase loads its length minus one and
    // counts down to zero before moving on. Button edges are only acted on
    // in IDLE; a kick edge wins over a punch edge in the same frame. A death
    // on either side parks the sequencer in IDLE, and round start clears
    // everything including the edge history.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
      if (!Reset_n) begin
        state_q     <= PH_IDLE;
        cnt_q       <= 4'd0;
        kick_q      <= 1'b0;
        landed_q    <= 1'b0;
        prevPunch_q <= 1'b0;
        prevKick_q  <= 1'b0;
      end else if (bus_io.startscreen) begin
        state_q     <= PH_IDLE;
        cnt_q       <= 4'd0;
        kick_q      <= 1'b0;
        landed_q    <= 1'b0;
        prevPunch_q <= 1'b0;
        prevKick_q  <= 1'b0;
      end else begin
        prevPunch_q <= punchIn[g];
        prevKick_q  <= kickIn[g];
        if (anyDeath) begin
          state_q  <= PH_IDLE;
          cnt_q    <= 4'd0;
          landed_q <= 1'b0;
        end else begin
          case (state_q)
            PH_IDLE: begin
              if (punchEdge || kickEdge) begin
                state_q  <= PH_WINDUP;
                cnt_q    <= WINDUP_LAST;
                kick_q   <= kickEdge;
                landed_q <= 1'b0;
              end
            end
            PH_WINDUP: begin
              if (cnt_q == 4'd0) begin
                state_q <= PH_ACTIVE;
                cnt_q   <= ACTIVE_LAST;
              end else begin
                cnt_q <= cnt_q - 4'd1;
              end
            end
            PH_ACTIVE: begin
              if (connects[g]) begin
                landed_q <= 1'b1;
              end
              if (cnt_q == 4'd0) begin
                state_q <= PH_RECOVER;
                cnt_q   <= RECOVER_LAST;
              end else begin
                cnt_q <= cnt_q - 4'd1;
              end
            end
            PH_RECOVER: begin
              if (cnt_q == 4'd0) begin
                state_q <= PH_IDLE;
              end else begin
                cnt_q <= cnt_q - 4'd1;
              end
            end
            default: begin
              state_q <= PH_IDLE;
              cnt_q   <= 4'd0;
            end
          endcase
        end
      end
    end
  end

  // Damage each fighter would take this frame: the attacker's latched type
  // picks the base value, and the defender's block flag in the same frame
  // cuts it to a quarter.
  assign dmgP1Raw = attackKick[1] ? KICK_FULL : PUNCH_FULL;
  assign dmgP2Raw = attackKick[0] ? KICK_FULL : PUNCH_FULL;
  assign dmgP1    = blockIn[0] ? (dmgP1Raw >> 2) : dmgP1Raw;
  assign dmgP2    = blockIn[1] ? (dmgP2Raw >> 2) : dmgP2Raw;

  // Next health values. Subtraction saturates at zero so a low health can
  // never wrap back up. Each side is updated on its own, so a trade in the
  // same frame damages both fighters.
  always_comb begin
    p1Health_d = p1Health_q;
    p2Health_d = p2Health_q;
    if (connects[1]) begin
      p1Health_d = (p1Health_q > dmgP1) ? (p1Health_q - dmgP1) : 8'd0;
    end
    if (connects[0]) begin
      p2Health_d = (p2Health_q > dmgP2) ? (p2Health_q - dmgP2) : 8'd0;
    end
  end

  // Health, hit pulses and death flags. Deaths are taken from the next
  // health value so they appear in the same frame as the killing blow.
  // Once anyone is dead, health is frozen and no further hits are reported
  // until round start reloads everything.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      p1Health_q <= HP_INIT;
      p2Health_q <= HP_INIT;
      p1Hit_q    <= 1'b0;
      p2Hit_q    <= 1'b0;
      deathR_q   <= 1'b0;
      deathL_q   <= 1'b0;
    end else if (bus_io.startscreen) begin
      p1Health_q <= HP_INIT;
      p2Health_q <= HP_INIT;
      p1Hit_q    <= 1'b0;
      p2Hit_q    <= 1'b0;
      deathR_q   <= 1'b0;
      deathL_q   <= 1'b0;
    end else if (anyDeath) begin
      p1Hit_q <= 1'b0;
      p2Hit_q <= 1'b0;
    end else begin
      p1Health_q <= p1Health_d;
      p2Health_q <= p2Health_d;
      p1Hit_q    <= connects[1];
      p2Hit_q    <= connects[0];
      deathR_q   <= (p1Health_d == 8'd0);
      deathL_q   <= (p2Health_d == 8'd0);
    end
  end

  assign bus_io.p1_health = p1Health_q;
  assign bus_io.p2_health = p2Health_q;
  assign bus_io.p1_hit    = p1Hit_q;
  assign bus_io.p2_hit    = p2Hit_q;
  assign bus_io.deathR    = deathR_q;
  assign bus_io.deathL    = deathL_q;
  assign bus_io.p1_phase  = phaseBits[1:0];
  assign bus_io.p2_phase  = phaseBits[3:2];

endmodule

// File: tb/tb_combat_resolver.sv
// ---------------------------------------------------------------------------
// tb_combat_resolver
// Directed, table-driven bench for combat_resolver. Each table row holds the
// inputs for one frame and the outputs expected in the following frame.
// ---------------------------------------------------------------------------
module tb_combat_resolver;

  typedef struct {
    logic       st;
    logic [2:0] a1;
    logic [2:0] a2;
    logic [1:0] ph1;
    logic [1:0] ph2;
    logic [7:0] h1;
    logic [7:0] h2;
    logic       hit1;
    logic       hit2;
    logic       dR;
    logic       dL;
  } vector_t;

  logic clk;
  logic rstN;
  int   total;
  int   bad;
  int   h1Model;
  vector_t tbl[$];

  combat_resolver_if bus();

  combat_resolver dut (
    .frame_clk (clk),
    .Reset_n   (rstN),
    .bus_io    (bus)
  );

  // Free-running frame clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected phase k frames after the edge frame, default phase lengths.
  function automatic logic [1:0] phaseAt(input int k);
    if (k < 2) return 2'd1;
    if (k < 5) return 2'd2;
    if (k < 11) return 2'd3;
    return 2'd0;
  endfunction

  function automatic int satSub(input int h, input int d);
    return (h > d) ? (h - d) : 0;
  endfunction

  function automatic void addVec(input logic st, input logic [2:0] a1,
                                 input logic [2:0] a2, input logic [1:0] ph1,
                                 input logic [1:0] ph2, input logic [7:0] h1,
                                 input logic [7:0] h2, input logic hit1,
                                 input logic hit2, input logic dR,
                                 input logic dL);
    vector_t v;
    v.st = st; v.a1 = a1; v.a2 = a2; v.ph1 = ph1; v.ph2 = ph2;
    v.h1 = h1; v.h2 = h2; v.hit1 = hit1; v.hit2 = hit2; v.dR = dR; v.dL = dL;
    tbl.push_back(v);
  endfunction

  function automatic vector_t resetVec();
    vector_t v;
    v.st = 1'b0; v.a1 = 3'b000; v.a2 = 3'b000; v.ph1 = 2'd0; v.ph2 = 2'd0;
    v.h1 = 8'd100; v.h2 = 8'd100; v.hit1 = 1'b0; v.hit2 = 1'b0;
    v.dR = 1'b0; v.dL = 1'b0;
    return v;
  endfunction

  task automatic setPos(input int x1, input int y1, input int x2, input int y2);
    bus.p1_x = 10'(x1);
    bus.p1_y = 10'(y1);
    bus.p2_x = 10'(x2);
    bus.p2_y = 10'(y2);
  endtask

  task automatic checkVal(input string name, input logic [7:0] act,
                          input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Compare every DUT output against one row's expectations.
  task automatic checkOutput(input vector_t v, input string tag);
    checkVal({tag, ".p1_phase"},  8'(bus.p1_phase),  8'(v.ph1));
    checkVal({tag, ".p2_phase"},  8'(bus.p2_phase),  8'(v.ph2));
    checkVal({tag, ".p1_health"}, bus.p1_health,     v.h1);
    checkVal({tag, ".p2_health"}, bus.p2_health,     v.h2);
    checkVal({tag, ".p1_hit"},    8'(bus.p1_hit),    8'(v.hit1));
    checkVal({tag, ".p2_hit"},    8'(bus.p2_hit),    8'(v.hit2));
    checkVal({tag, ".deathR"},    8'(bus.deathR),    8'(v.dR));
    checkVal({tag, ".deathL"},    8'(bus.deathL),    8'(v.dL));
  endtask

  // Drive one frame of inputs, let the rising edge sample them, then check
  // the registered outputs just after the edge.
  task automatic applyStimulus(input vector_t v, input string tag);
    bus.startscreen = v.st;
    {bus.p1_punch, bus.p1_kick, bus.p1_block} = v.a1;
    {bus.p2_punch, bus.p2_kick, bus.p2_block} = v.a2;
    @(posedge clk);
    #1;
    checkOutput(v, tag);
  endtask

  task automatic runTable(input string tag);
    foreach (tbl[i]) applyStimulus(tbl[i], $sformatf("%s[%0d]", tag, i));
    tbl.delete();
  endtask

  // Fighter 2 attacks once, fighter 1 optionally blocking; h1m tracks the
  // expected fighter 1 health across calls.
  task automatic queueAttack(input logic [2:0] act2, input logic blk,
                             inout int h1m);
    int full;
    int d;
    int after;
    full  = act2[1] ? 8 : 5;
    d     = blk ? (act2[1] ? 2 : 1) : full;
    after = satSub(h1m, d);
    for (int k = 0; k < 12; k++)
      addVec(1'b0, {2'b00, blk}, (k == 0) ? act2 : 3'b000, 2'd0, phaseAt(k),
             8'((k >= 3) ? after : h1m), 8'd100, (k == 3), 1'b0, 1'b0, 1'b0);
    h1m = after;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rstN  = 1'b0;
    bus.startscreen = 1'b0;
    {bus.p1_punch, bus.p1_kick, bus.p1_block} = 3'b000;
    {bus.p2_punch, bus.p2_kick, bus.p2_block} = 3'b000;
    setPos(480, 360, 380, 360);

    // Outputs while held in reset.
    #12;
    checkOutput(resetVec(), "reset");
    rstN = 1'b1;

    // Fighter 2 punch, unblocked, dx 100.
    for (int k = 0; k < 12; k++)
      addVec(1'b0, 3'b000, (k < 2) ? 3'b100 : 3'b000, 2'd0, phaseAt(k),
             (k >= 3) ? 8'd95 : 8'd100, 8'd100, (k == 3), 1'b0, 1'b0, 1'b0);
    runTable("p2punch");

    // Round start, then a held kick against a held block.
    addVec(1'b1, 3'b000, 3'b000, 2'd0, 2'd0, 8'd100, 8'd100, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++)
      addVec(1'b0, 3'b001, 3'b010, 2'd0, phaseAt(k),
             (k >= 3) ? 8'd98 : 8'd100, 8'd100, (k == 3), 1'b0, 1'b0, 1'b0);
    runTable("p2kickBlocked");

    // dx 120: punch out of reach, kick in reach, then dy 61 kick misses.
    setPos(500, 360, 380, 360);
    for (int k = 0; k < 12; k++)
      addVec(1'b0, (k == 0) ? 3'b100 : 3'b000, 3'b000, phaseAt(k), 2'd0,
             8'd98, 8'd100, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++)
      addVec(1'b0, (k == 0) ? 3'b010 : 3'b000, 3'b000, phaseAt(k), 2'd0,
             8'd98, (k >= 3) ? 8'd92 : 8'd100, 1'b0, (k == 3), 1'b0, 1'b0);
    runTable("reach");
    setPos(500, 360, 380, 421);
    for (int k = 0; k < 12; k++)
      addVec(1'b0, (k == 0) ? 3'b010 : 3'b000, 3'b000, phaseAt(k), 2'd0,
             8'd98, 8'd92, 1'b0, 1'b0, 1'b0, 1'b0);
    runTable("height");

    // Simultaneous punches at dx 100 trade damage in the same frame.
    setPos(480, 360, 380, 360);
    addVec(1'b1, 3'b000, 3'b000, 2'd0, 2'd0, 8'd100, 8'd100, 0, 0, 0, 0);
    for (int k = 0; k < 12; k++)
      addVec(1'b0, (k == 0) ? 3'b100 : 3'b000, (k == 0) ? 3'b100 : 3'b000,
             phaseAt(k), phaseAt(k), (k >= 3) ? 8'd95 : 8'd100,
             (k >= 3) ? 8'd95 : 8'd100, (k == 3), (k == 3), 1'b0, 1'b0);
    runTable("trade");

    // Wear fighter 1 down to 3: twelve full kicks, one blocked punch.
    addVec(1'b1, 3'b000, 3'b000, 2'd0, 2'd0, 8'd100, 8'd100, 0, 0, 0, 0);
    h1Model = 100;
    for (int n = 0; n < 12; n++) queueAttack(3'b010, 1'b0, h1Model);
    queueAttack(3'b100, 1'b1, h1Model);
    runTable("preload");

    // Finishing kick saturates to zero; death freezes both sequencers.
    addVec(1'b0, 3'b000, 3'b010, 2'd0, 2'd1, 8'd3, 8'd100, 0, 0, 0, 0);
    addVec(1'b0, 3'b000, 3'b000, 2'd0, 2'd1, 8'd3, 8'd100, 0, 0, 0, 0);
    addVec(1'b0, 3'b000, 3'b000, 2'd0, 2'd2, 8'd3, 8'd100, 0, 0, 0, 0);
    addVec(1'b0, 3'b000, 3'b000, 2'd0, 2'd2, 8'd0, 8'd100, 1, 0, 1, 0);
    addVec(1'b0, 3'b000, 3'b000, 2'd0, 2'd0, 8'd0, 8'd100, 0, 0, 1, 0);
    addVec(1'b0, 3'b100, 3'b010, 2'd0, 2'd0, 8'd0, 8'd100, 0, 0, 1, 0);
    addVec(1'b0, 3'b000, 3'b000, 2'd0, 2'd0, 8'd0, 8'd100, 0, 0, 1, 0);
    addVec(1'b0, 3'b010, 3'b000, 2'd0, 2'd0, 8'd0, 8'd100, 0, 0, 1, 0);
    addVec(1'b0, 3'b000, 3'b000, 2'd0, 2'd0, 8'd0, 8'd100, 0, 0, 1, 0);
    addVec(1'b1, 3'b000, 3'b000, 2'd0, 2'd0, 8'd100, 8'd100, 0, 0, 0, 0);
    runTable("death");

    // Fighter 1 punch lands, then reset arrives while still ACTIVE.
    addVec(1'b0, 3'b100, 3'b000, 2'd1, 2'd0, 8'd100, 8'd100, 0, 0, 0, 0);
    addVec(1'b0, 3'b000, 3'b000, 2'd1, 2'd0, 8'd100, 8'd100, 0, 0, 0, 0);
    addVec(1'b0, 3'b000, 3'b000, 2'd2, 2'd0, 8'd100, 8'd100, 0, 0, 0, 0);
    addVec(1'b0, 3'b000, 3'b000, 2'd2, 2'd0, 8'd100, 8'd95, 0, 1, 0, 0);
    runTable("preReset");
    #1;
    rstN = 1'b0;
    #1;
    checkOutput(resetVec(), "midReset");
    #1;
    rstN = 1'b1;
    for (int k = 0; k < 13; k++) tbl.push_back(resetVec());
    runTable("postReset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
